jstk_poll_sched: RTL and testbench

JSTK_POLL_SCHED -- requirements
Module: jstk_poll_sched

---
 rtl/jstk_poll_sched.sv | 136 +++++++++++++
 tb/tb_jstk_poll_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_sched.sv
// Alternating two-joystick poll scheduler sharing one SPI engine.
// Define JSTK_POLL_TIMEOUT_EN to build the WAIT timeout, ABORT path and err flags.
module jstk_poll_sched #(
    parameter int POLL_CYCLES    = 50000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic        err_clr,
    input  logic        spi_done,
    input  logic [39:0] spi_dout,
    output logic        spi_start,
    output logic [1:0]  ss_n,
    output logic [39:0] jstk1_data,
    output logic [39:0] jstk2_data,
    output logic        jstk1_valid,
    output logic        jstk2_valid,
    output logic [1:0]  err,
    output logic        overrun
);

    localparam int SW = $clog2(POLL_CYCLES);

    typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, ABORT} state_t;

    if (POLL_CYCLES < 2 || POLL_CYCLES > (1 << 20) ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_param_err
        $error("jstk_poll_sched: parameter out of range");
    end

    state_t        state, state_nxt;
    logic [SW-1:0] slot_cnt;
    logic          tick;
    logic          cur;
    logic          tmo_hit;

    assign tick = (slot_cnt == SW'(POLL_CYCLES - 1));

    // Slot timing is independent of en so the poll rate never drifts.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)       slot_cnt <= '0;
        else if (tick) slot_cnt <= '0;
        else           slot_cnt <= slot_cnt + SW'(1);
    end

`ifdef JSTK_POLL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;
    logic [1:0]    err_q;
    logic          abort_set;

    assign tmo_hit   = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign abort_set = tmo_hit && !spi_done;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                tmo_cnt <= '0;
        else if (state == WAIT) tmo_cnt <= tmo_cnt + TW'(1);
        else                    tmo_cnt <= '0;
    end

    // A set in the same cycle as err_clr survives the clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) err_q <= 2'b00;
        else     err_q <= (err_clr ? 2'b00 : err_q) | ({cur, ~cur} & {2{abort_set}});
    end

    assign err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err     = 2'b00;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick && en) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (spi_done)     state_nxt = CAPTURE;
                else if (tmo_hit) state_nxt = ABORT;
            end
            CAPTURE: state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_start   = 1'b0;
        ss_n        = 2'b11;
        jstk1_valid = 1'b0;
        jstk2_valid = 1'b0;
        case (state)
            START: begin
                spi_start = 1'b1;
                ss_n[cur] = 1'b0;
            end
            WAIT:    ss_n[cur] = 1'b0;
            CAPTURE: begin
                jstk1_valid = ~cur;
                jstk2_valid = cur;
            end
            default: ;
        endcase
    end

    // Joystick pointer advances on both outcomes so a dead stick cannot starve the other.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                     cur <= 1'b0;
        else if (state == CAPTURE || state == ABORT) cur <= ~cur;
    end

    // Frame lands on the done edge so data and valid appear together in CAPTURE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            jstk1_data <= '0;
            jstk2_data <= '0;
        end else if (state == WAIT && spi_done) begin
            if (!cur) jstk1_data <= spi_dout;
            else      jstk2_data <= spi_dout;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) overrun <= 1'b0;
        else     overrun <= (overrun & ~err_clr) | (tick && en && state != IDLE);
    end

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Randomized bench for jstk_poll_sched: transaction-level timing model predicts every output each cycle.
module tb_jstk_poll_sched;

    localparam int P      = 8;
    localparam int T      = 12;
    localparam int SILENT = 0;
`ifdef JSTK_POLL_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr, en, err_clr, spi_done;
    logic [39:0] spi_dout;
    logic        spi_start;
    logic [1:0]  ss_n;
    logic [39:0] jstk1_data, jstk2_data;
    logic        jstk1_valid, jstk2_valid;
    logic [1:0]  err;
    logic        overrun;

    jstk_poll_sched #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .clr(clr), .en(en), .err_clr(err_clr),
        .spi_done(spi_done), .spi_dout(spi_dout),
        .spi_start(spi_start), .ss_n(ss_n),
        .jstk1_data(jstk1_data), .jstk2_data(jstk2_data),
        .jstk1_valid(jstk1_valid), .jstk2_valid(jstk2_valid),
        .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction model: one outstanding poll described by start/end cycle and outcome.
    int          cyc;
    bit          m_busy;
    int          m_ts, m_te;
    bit          m_cap;
    int          m_joy;
    logic [39:0] m_data [2];
    logic [1:0]  m_err;
    bit          m_ovr;

    // SPI engine stand-in.
    int          eng_done;
    logic [39:0] eng_frame;
    int          eng_cnt;
    int          cur_d;
    int          mode;

    function automatic logic [39:0] rand40();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    function automatic int pick_d();
        int r;
        if (mode == 0) return 5;
        r = int'($urandom % 16);
        if (TMO) begin
            if (r < 2)  return SILENT;
            if (r < 4)  return T + 1 + int'($urandom % 2);
            if (r == 4) return T;
            return 1 + int'($urandom % T);
        end
        return 1 + int'($urandom % 14);
    endfunction

    task automatic do_reset();
        #2 clr = 1'b1;
        #1;
        chk("rst_ss_n", ss_n, 2'b11);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_jstk1_data", jstk1_data, 40'h0);
        chk("rst_jstk2_data", jstk2_data, 40'h0);
        chk("rst_valid", {jstk2_valid, jstk1_valid}, 2'b00);
        chk("rst_err", err, 2'b00);
        chk("rst_overrun", overrun, 1'b0);
        spi_done = 1'b0;
        err_clr  = 1'b0;
        #1 clr = 1'b0;
        m_busy = 0; m_joy = 0; m_err = 2'b00; m_ovr = 0;
        m_data[0] = '0; m_data[1] = '0;
        eng_done = -1;
        cyc = 1;
    endtask

    initial begin
        logic [1:0]  exp_ssn;
        logic [1:0]  exp_v;
        logic [1:0]  err_n;
        bit          ovr_n, tick, want_rst;
        int          want_k;

        clr = 1'b1; en = 1'b0; err_clr = 1'b0; spi_done = 1'b0; spi_dout = '0;
        mode = 0; eng_cnt = 0; cur_d = pick_d(); want_rst = 0; want_k = 0;
        @(negedge clk);
        do_reset();
        en = 1'b1;

        for (int k = 0; k < 2400; k++) begin
            @(negedge clk);
            if (k == 300) mode = 1;
            if (k == 1000 || k == 1800) begin want_rst = 1; want_k = k; end

            exp_ssn = 2'b11;
            if (m_busy && cyc >= m_ts && cyc < m_te) exp_ssn[m_joy] = 1'b0;
            exp_v = 2'b00;
            if (m_busy && cyc == m_te && m_cap) exp_v[m_joy] = 1'b1;
            chk("spi_start", spi_start, m_busy && cyc == m_ts);
            chk("ss_n", ss_n, exp_ssn);
            chk("valid", {jstk2_valid, jstk1_valid}, exp_v);
            chk("jstk1_data", jstk1_data, m_data[0]);
            chk("jstk2_data", jstk2_data, m_data[1]);
            chk("err", err, m_err);
            chk("overrun", overrun, m_ovr);

            // Async clear while joystick 1 sits in WAIT.
            if (want_rst && m_busy && cyc > m_ts && cyc < m_te && m_joy == 0) begin
                do_reset();
                want_rst = 0;
                continue;
            end
            if (want_rst && k - want_k > 300) begin
                chk("rst_wait_timeout", 1, 0);
                want_rst = 0;
            end

            if (mode == 0) en = 1'b1;
            else if (en ? ($urandom % 40 == 0) : ($urandom % 8 == 0)) en = ~en;
            err_clr = (mode == 1) && ($urandom % 16 == 0);

            spi_done = 1'b0;
            spi_dout = rand40();
            if (cyc == eng_done) begin
                spi_done = 1'b1;
                spi_dout = eng_frame;
                eng_done = -1;
            end else if (mode == 1 && !m_busy && eng_done < 0 && $urandom % 10 == 0) begin
                spi_done = 1'b1;
            end
            if (spi_start === 1'b1) begin
                eng_done  = (cur_d == SILENT) ? -1 : cyc + cur_d;
                eng_frame = (mode == 0) ? (eng_cnt[0] ? 40'h5A00000000 : 40'hA500000000) : rand40();
                eng_cnt++;
                cur_d = pick_d();
            end

            tick  = (cyc % P) == P - 1;
            err_n = err_clr ? 2'b00 : m_err;
            ovr_n = err_clr ? 1'b0 : m_ovr;
            if (m_busy && cyc == m_te - 1) begin
                if (m_cap) m_data[m_joy] = spi_dout;
                else       err_n[m_joy] = 1'b1;
            end
            if (tick && en) begin
                if (m_busy) ovr_n = 1'b1;
                else begin
                    m_busy = 1;
                    m_ts   = cyc + 1;
                    if (TMO && (cur_d == SILENT || cur_d > T)) begin
                        m_cap = 0; m_te = m_ts + T + 1;
                    end else begin
                        m_cap = 1; m_te = m_ts + cur_d + 1;
                    end
                end
            end
            if (m_busy && cyc == m_te) begin
                m_busy = 0;
                m_joy  = 1 - m_joy;
            end
            m_err = err_n;
            m_ovr = ovr_n;
            cyc++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
